// File: rtl/game_packet_rx.sv
// game_packet_rx: RMII dibit receiver that strips preamble/SFD/MAC header and
// presents the 44-bit kart game-state word; define GAME_PACKET_FCS_CHECK_EN
// to hold the word until the Ethernet FCS has been verified.
module game_packet_rx #(
   parameter int HDR_BYTES     = 14,
   parameter int PAYLOAD_BYTES = 6
) (
   input  logic        clk_in,
   input  logic        rst_in_n,
   input  logic        crsdv,
   input  logic [1:0]  rxd,
   output logic        axiov,
   output logic [43:0] axiod,
   output logic        crc_err,
   output logic [15:0] frame_cnt
);
   localparam int PW       = 8 * PAYLOAD_BYTES;
   localparam int HDR_DIB  = 4 * HDR_BYTES;
   localparam int PAY_DIB  = 4 * PAYLOAD_BYTES;
   localparam int CW       = $clog2((HDR_DIB > PAY_DIB ? HDR_DIB : PAY_DIB) + 1);
   localparam logic [CW-1:0] HDR_LAST = CW'(HDR_DIB - 1);
   localparam logic [CW-1:0] PAY_LAST = CW'(PAY_DIB - 1);

   typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, PAYLOAD, TAIL, DROP} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [5:0]      byte_q, byte_d;
   logic [PW-1:0]   word_q, word_d;
   logic            axiov_q, axiov_d;
   logic [43:0]     axiod_q, axiod_d;
   logic            crc_err_q, crc_err_d;
   logic [15:0]     frame_cnt_q, frame_cnt_d;
   logic            accept, reject;

`ifdef GAME_PACKET_FCS_CHECK_EN
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
   logic [31:0] crc_q, crc_d;

   function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 2; i++) r = (r[0] ^ d[i]) ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
      return r;
   endfunction

   // CRC is seeded while in the preamble and folds in every valid dibit after the SFD
   always_comb begin
      crc_d = crc_q;
      if (state_q == PREAMBLE) crc_d = '1;
      else if (crsdv && (state_q == HEADER || state_q == PAYLOAD || state_q == TAIL))
         crc_d = crc_dibit(crc_q, rxd);
   end

   // CRC register
   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) crc_q <= '1;
      else           crc_q <= crc_d;
   end

   assign accept = state_q == TAIL && !crsdv && crc_q == CRC_RESIDUE;
   assign reject = state_q == TAIL && !crsdv && crc_q != CRC_RESIDUE;
`else
   assign accept = state_q == PAYLOAD && crsdv && cnt_q == PAY_LAST;
   assign reject = 1'b0;
`endif

   // Frame FSM, dibit/byte assembly and registered output updates
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      byte_d  = {rxd, byte_q[5:2]};
      word_d  = word_q;
      case (state_q)
         IDLE:     if (crsdv && rxd == 2'b01) state_d = PREAMBLE;
         PREAMBLE: begin
            if (!crsdv) state_d = IDLE;
            else if (rxd == 2'b11) begin
               state_d = HEADER;
               cnt_d   = '0;
            end else if (rxd != 2'b01) state_d = DROP;
         end
         HEADER: begin
            if (!crsdv) state_d = IDLE;
            else if (cnt_q == HDR_LAST) begin
               state_d = PAYLOAD;
               cnt_d   = '0;
            end
         end
         PAYLOAD: begin
            if (!crsdv) state_d = IDLE;
            else begin
               if (cnt_q[1:0] == 2'b11) word_d = {word_q[PW-9:0], rxd, byte_q};
               if (cnt_q == PAY_LAST) state_d = TAIL;
            end
         end
         TAIL:     if (!crsdv) state_d = IDLE;
         DROP:     if (!crsdv) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
      axiov_d     = accept;
      crc_err_d   = reject;
      axiod_d     = accept ? word_d[PW-1 -: 44] : axiod_q;
      frame_cnt_d = frame_cnt_q + {15'd0, accept};
   end

   // State and output registers
   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         byte_q      <= '0;
         word_q      <= '0;
         axiov_q     <= 1'b0;
         axiod_q     <= '0;
         crc_err_q   <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         byte_q      <= byte_d;
         word_q      <= word_d;
         axiov_q     <= axiov_d;
         axiod_q     <= axiod_d;
         crc_err_q   <= crc_err_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign axiov     = axiov_q;
   assign axiod     = axiod_q;
   assign crc_err   = crc_err_q;
   assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_game_packet_rx.sv
// tb_game_packet_rx: directed frame-level checks for game_packet_rx
module tb_game_packet_rx;
   logic        clk_in = 1'b0;
   logic        rst_in_n = 1'b0;
   logic        crsdv = 1'b0;
   logic [1:0]  rxd = 2'b00;
   logic        axiov, crc_err;
   logic [43:0] axiod;
   logic [15:0] frame_cnt;

   int n_cmp = 0, n_fail = 0;
   int nv, ne, nboth, vstep, estep, sc;
   logic [15:0] exp_cnt = 16'd0;
   logic [43:0] exp_d = 44'd0;

`ifdef GAME_PACKET_FCS_CHECK_EN
   localparam int VSTEP = 288;
`else
   localparam int VSTEP = 111;
`endif

   typedef struct {
      logic [47:0] w;
      logic [10:0] x;
      logic [10:0] y;
      logic [8:0]  dir;
      logic [2:0]  game;
      logic        rst;
   } vec_t;
   vec_t tv [5];

   game_packet_rx dut (
      .clk_in(clk_in), .rst_in_n(rst_in_n), .crsdv(crsdv), .rxd(rxd),
      .axiov(axiov), .axiod(axiod), .crc_err(crc_err), .frame_cnt(frame_cnt)
   );

   always #10 clk_in = ~clk_in;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic step(input logic dv, input logic [1:0] d);
      crsdv = dv;
      rxd   = d;
      @(posedge clk_in);
      #1;
      if (axiov) begin nv++; vstep = sc; end
      if (crc_err) begin ne++; estep = sc; end
      if (axiov && crc_err) nboth++;
      sc++;
   endtask

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) r = (r[0] ^ d[i]) ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
      return r;
   endfunction

   // mode 0 good, 1 payload bit 40 flipped after FCS, 2 runt, 3 bad preamble, 4 reset mid-payload
   task automatic send_frame(input logic [47:0] w, input int mode);
      logic [7:0]  b [72];
      logic [7:0]  cur;
      logic [1:0]  dib;
      logic [31:0] c;
      int p;
      for (int i = 0; i < 7; i++) b[i] = 8'h55;
      b[7] = 8'hD5;
      for (int i = 0; i < 12; i++) b[8+i] = 8'(8'h10 + i);
      b[20] = 8'h88;
      b[21] = 8'hB5;
      for (int i = 0; i < 6; i++) b[22+i] = w[47-8*i -: 8];
      for (int i = 28; i < 68; i++) b[i] = 8'h00;
      c = 32'hFFFFFFFF;
      for (int i = 8; i < 68; i++) c = crc_byte(c, b[i]);
      c = ~c;
      for (int j = 0; j < 4; j++) b[68+j] = c[8*j +: 8];
      if (mode == 1) b[22][0] = ~b[22][0];
      nv = 0; ne = 0; nboth = 0; vstep = -1; estep = -1; sc = 0;
      for (int k = 0; k < 288; k++) begin
         p   = k - 88;
         cur = b[k/4];
         dib = cur[2*(k%4) +: 2];
         if (mode == 3 && k == 5) dib = 2'b10;
         if (mode == 2 && p == 11) break;
         if (mode == 4 && p == 5) begin
            crsdv = 1'b1;
            rxd = dib;
            rst_in_n = 1'b0;
            #2;
            chk("rst_mid_axiov", axiov, 0);
            chk("rst_mid_crc_err", crc_err, 0);
            chk("rst_mid_axiod", axiod, 0);
            chk("rst_mid_frame_cnt", frame_cnt, 0);
            crsdv = 1'b0;
            @(posedge clk_in);
            @(posedge clk_in);
            #5 rst_in_n = 1'b1;
            @(posedge clk_in);
            #1;
            return;
         end
         step(1'b1, dib);
      end
      step(1'b0, 2'b00);
   endtask

   task automatic expect_result(input string tag, input logic acc, input logic err);
      chk({tag, "_axiov_pulses"}, nv, {63'd0, acc});
      chk({tag, "_crc_err_pulses"}, ne, {63'd0, err});
      chk({tag, "_both_high"}, nboth, 0);
      if (acc) chk({tag, "_axiov_time"}, vstep, VSTEP);
      if (err) chk({tag, "_crc_err_time"}, estep, 288);
      chk({tag, "_axiod"}, axiod, exp_d);
      chk({tag, "_frame_cnt"}, frame_cnt, exp_cnt);
   endtask

   initial begin
      tv[0] = '{48'h2581902D0600, 11'd300,  11'd200,  9'd90,  3'd3, 1'b0};
      tv[1] = '{48'hFFFFFFFFFFFF, 11'd2047, 11'd2047, 9'd511, 3'd7, 1'b1};
      tv[2] = '{48'hAAAAAAAAAAAA, 11'd1365, 11'd1365, 9'd341, 3'd5, 1'b1};
      tv[3] = '{48'h555555555555, 11'd682,  11'd682,  9'd170, 3'd2, 1'b0};
      tv[4] = '{48'h000000000000, 11'd0,    11'd0,    9'd0,   3'd0, 1'b0};

      repeat (3) @(posedge clk_in);
      #1;
      chk("reset_axiov", axiov, 0);
      chk("reset_crc_err", crc_err, 0);
      chk("reset_axiod", axiod, 0);
      chk("reset_frame_cnt", frame_cnt, 0);
      rst_in_n = 1'b1;
      step(1'b0, 2'b00);
      step(1'b0, 2'b00);

      for (int i = 0; i < 5; i++) begin
         send_frame(tv[i].w, 0);
         exp_cnt++;
         exp_d = tv[i].w[47:4];
         expect_result($sformatf("good%0d", i), 1'b1, 1'b0);
         chk($sformatf("good%0d_x", i), axiod[43:33], tv[i].x);
         chk($sformatf("good%0d_y", i), axiod[31:21], tv[i].y);
         chk($sformatf("good%0d_dir", i), axiod[19:11], tv[i].dir);
         chk($sformatf("good%0d_game", i), axiod[7:5], tv[i].game);
         chk($sformatf("good%0d_reset", i), axiod[3], tv[i].rst);
      end

      send_frame(tv[0].w, 1);
`ifdef GAME_PACKET_FCS_CHECK_EN
      expect_result("bad_fcs", 1'b0, 1'b1);
`else
      exp_cnt++;
      exp_d = tv[0].w[47:4] ^ (44'd1 << 36);
      expect_result("bad_fcs", 1'b1, 1'b0);
`endif

      send_frame(tv[1].w, 2);
      expect_result("runt", 1'b0, 1'b0);
      send_frame(tv[2].w, 0);
      exp_cnt++;
      exp_d = tv[2].w[47:4];
      expect_result("after_runt", 1'b1, 1'b0);

      send_frame(tv[3].w, 3);
      expect_result("bad_preamble", 1'b0, 1'b0);
      send_frame(tv[0].w, 0);
      exp_cnt++;
      exp_d = tv[0].w[47:4];
      expect_result("after_bad_preamble", 1'b1, 1'b0);

      send_frame(tv[1].w, 4);
      exp_cnt = 16'd0;
      exp_d = 44'd0;
      chk("after_reset_idle_cnt", frame_cnt, exp_cnt);
      send_frame(tv[0].w, 0);
      exp_cnt++;
      exp_d = tv[0].w[47:4];
      expect_result("after_reset", 1'b1, 1'b0);
      chk("after_reset_x", axiod[43:33], tv[0].x);
      chk("after_reset_dir", axiod[19:11], tv[0].dir);

      for (int i = 2; i < 5; i++) begin
         send_frame(tv[i].w, 0);
         exp_cnt++;
         exp_d = tv[i].w[47:4];
         expect_result($sformatf("b2b%0d", i), 1'b1, 1'b0);
      end

      force dut.frame_cnt_q = 16'hFFFF;
      step(1'b0, 2'b00);
      release dut.frame_cnt_q;
      step(1'b0, 2'b00);
      exp_cnt = 16'hFFFF;
      send_frame(tv[3].w, 0);
      exp_cnt++;
      exp_d = tv[3].w[47:4];
      expect_result("wrap", 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
